// File: rtl/comparador_serie_di.sv
// Serial magnitude comparator: resolves DIGITS_PER_CYCLE bits per clock, LSB chunk first.
// Optional SIGNED_CMP_EN treats operands as two's complement (MSB inverted at latch).
module comparador_serie_di #(
  parameter int WIDTH            = 8,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic [1:0]       rel
);

  localparam int N  = WIDTH / DIGITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % DIGITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("comparador_serie_di: WIDTH must be >=2 and divisible by DIGITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {REL_EQ = 2'b00, REL_LT = 2'b01, REL_GT = 2'b10} rel_t;

  state_t           r_state, w_state_nxt;
  rel_t             r_rel, w_rel_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_in, w_b_in;
  logic [1:0]       r_mode;
  logic             r_result, w_result_nxt;
  logic [CW-1:0]    r_cnt;
  logic             w_last;

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign w_a_in = {~A[WIDTH-1], A[WIDTH-2:0]};
  assign w_b_in = {~B[WIDTH-1], B[WIDTH-2:0]};
`else
  assign w_a_in = A;
  assign w_b_in = B;
`endif

  assign w_last = (r_cnt == CW'(N - 1));

  // Operands shift right each cycle, so the current chunk is always at bit 0.
  always_comb begin
    w_rel_nxt = r_rel;
    for (int unsigned i = 0; i < DIGITS_PER_CYCLE; i++) begin
      if (r_a[i] < r_b[i])      w_rel_nxt = REL_LT;
      else if (r_a[i] > r_b[i]) w_rel_nxt = REL_GT;
    end
  end

  always_comb begin
    w_result_nxt = 1'b0;
    case (r_mode)
      2'b00:   w_result_nxt = (w_rel_nxt != REL_GT);
      2'b01:   w_result_nxt = (w_rel_nxt == REL_LT);
      2'b10:   w_result_nxt = (w_rel_nxt == REL_EQ);
      default: w_result_nxt = (w_rel_nxt == REL_GT);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= '0;
      r_rel    <= REL_EQ;
      r_result <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= w_a_in;
            r_b    <= w_b_in;
            r_mode <= mode;
            r_rel  <= REL_EQ;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> DIGITS_PER_CYCLE;
          r_b   <= r_b >> DIGITS_PER_CYCLE;
          r_rel <= w_rel_nxt;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          if (w_last) r_result <= w_result_nxt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    result = r_result;
    rel    = r_rel;
  end

endmodule

// File: tb/tb_comparador_serie_di.sv
// Directed bench for comparador_serie_di: D=1 and D=4 instances, latency, handshake and reset abort.
module tb_comparador_serie_di;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start4;
  logic [7:0] A, B;
  logic [1:0] mode;
  logic       busy1, done1, result1;
  logic [1:0] rel1;
  logic       busy4, done4, result4;
  logic [1:0] rel4;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  comparador_serie_di #(.WIDTH(8), .DIGITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(A), .B(B), .mode(mode),
    .busy(busy1), .done(done1), .result(result1), .rel(rel1)
  );

  comparador_serie_di #(.WIDTH(8), .DIGITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(A), .B(B), .mode(mode),
    .busy(busy4), .done(done4), .result(result4), .rel(rel4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and consumes the accepting edge (edge 0).
  task automatic start_op(input bit sel4, input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    A = a; B = b; mode = m;
    if (sel4) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
  endtask

  task automatic wait_done(input bit sel4, output int edges);
    edges = 0;
    while (edges < 40) begin
      tick();
      edges++;
      if ((sel4 ? done4 : done1) === 1'b1) break;
    end
  endtask

  int e, nd, kd, e1, e2;
  logic [1:0] exp_rel;
  logic       exp_res;

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    A = '0; B = '0; mode = '0;
    tick(); tick();
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_result1", result1, 0);
    chk("rst_rel1", rel1, 0);
    chk("rst_busy4", busy4, 0);
    rst_n = 1'b1;
    tick();

    // T1: equal operands, A<=B
    start_op(0, 8'h05, 8'h05, 2'b00);
    chk("t1_busy_run", busy1, 1);
    wait_done(0, e);
    chk("t1_latency", e, 8);
    chk("t1_result", result1, 1);
    chk("t1_rel", rel1, 0);
    chk("t1_busy_done", busy1, 1);
    tick();
    chk("t1_done_pulse", done1, 0);
    chk("t1_busy_idle", busy1, 0);
    chk("t1_result_held", result1, 1);

    // T4: reset mid-run, then a fresh op
    start_op(0, 8'h80, 8'h7F, 2'b00);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy1, 0);
    chk("t4_rst_done", done1, 0);
    chk("t4_rst_result", result1, 0);
    chk("t4_rst_rel", rel1, 0);
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done1 === 1'b1 || busy1 === 1'b1) nd++;
    end
    chk("t4_no_done", nd, 0);
    start_op(0, 8'hFF, 8'h00, 2'b11);
    wait_done(0, e);
    chk("t4_latency", e, 8);
`ifdef SIGNED_CMP_EN
    exp_res = 1'b0; exp_rel = 2'b01;
`else
    exp_res = 1'b1; exp_rel = 2'b10;
`endif
    chk("t4_result", result1, exp_res);
    chk("t4_rel", rel1, exp_rel);
    tick();

    // T2: 0x80 vs 0x7F, A<B
    start_op(0, 8'h80, 8'h7F, 2'b01);
    wait_done(0, e);
`ifdef SIGNED_CMP_EN
    exp_res = 1'b1; exp_rel = 2'b01;
`else
    exp_res = 1'b0; exp_rel = 2'b10;
`endif
    chk("t2_latency", e, 8);
    chk("t2_result", result1, exp_res);
    chk("t2_rel", rel1, exp_rel);
    tick();

    // T3: A>B with a start during RUN and operand changes after acceptance
    start_op(0, 8'h12, 8'h21, 2'b11);
    A = 8'hFF; B = 8'h00; mode = 2'b00;
    nd = 0; kd = 0;
    for (int k = 1; k <= 12; k++) begin
      start1 = (k == 3);
      tick();
      start1 = 1'b0;
      if (done1 === 1'b1) begin nd++; kd = k; end
    end
    chk("t3_done_count", nd, 1);
    chk("t3_done_edge", kd, 8);
    chk("t3_result", result1, 0);
    chk("t3_rel", rel1, 1);
    chk("t3_idle", busy1, 0);

    // T5: D=4 instance
    start_op(1, 8'h3C, 8'h3C, 2'b10);
    wait_done(1, e);
    chk("t5_latency", e, 2);
    chk("t5_result", result4, 1);
    chk("t5_rel", rel4, 0);
    tick();
    chk("t5_done_pulse", done4, 0);
    start_op(1, 8'h1F, 8'h20, 2'b00);
    wait_done(1, e);
    chk("t5b_latency", e, 2);
    chk("t5b_result", result4, 1);
    chk("t5b_rel", rel4, 1);
    tick();

    // T6: start held high, back-to-back operations
    A = 8'h01; B = 8'h02; mode = 2'b01;
    start1 = 1'b1;
    e1 = -1; e2 = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done1 === 1'b1) begin
        if (e1 < 0) e1 = k;
        else if (e2 < 0) e2 = k;
      end
    end
    start1 = 1'b0;
    chk("t6_first_done", e1, 8);
    chk("t6_gap", e2 - e1, 10);
    chk("t6_result", result1, 1);
    chk("t6_rel", rel1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
